// File: rtl/bw_mac_pkg.sv
// Shared types and constants for the Baugh-Wooley dot-product accumulator.
package bw_mac_pkg;

  localparam int ACC_W_DEFAULT = 10;
  localparam int CNT_W_DEFAULT = 4;
  localparam int PROD_W        = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } bw_state_e;

endpackage

// File: rtl/bw_sat_add.sv
// Signed ACC_W adder with overflow flag.
// Optional feature macro: BW_ACC_SAT_EN (clamp on overflow instead of wrapping).
module bw_sat_add #(
  parameter int ACC_W = 10
) (
  input  logic [ACC_W-1:0] a_i,
  input  logic [ACC_W-1:0] b_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             ovf_o
);

  logic [ACC_W-1:0] raw;

  // Two's complement add; overflow when operand signs match but result sign differs.
  always_comb begin
    raw   = a_i + b_i;
    ovf_o = (a_i[ACC_W-1] == b_i[ACC_W-1]) && (raw[ACC_W-1] != a_i[ACC_W-1]);
`ifdef BW_ACC_SAT_EN
    if (ovf_o) begin
      // Both operands share a sign, so a_i's sign selects the rail.
      sum_o = a_i[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      sum_o = raw;
    end
`else
    sum_o = raw;
`endif
  end

endmodule

// File: rtl/bw_dot_product_accumulator.sv
// Accumulates a vector of signed 8-bit products into an ACC_W signed result.
// IDLE takes the first term and latches the length, ACC sums the rest,
// HOLD presents the result until the consumer takes it.
// Optional feature macro: BW_ACC_SAT_EN (saturating accumulation, see bw_sat_add).
module bw_dot_product_accumulator
  import bw_mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic [CNT_W-1:0]  cfg_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf,
  output logic              busy
);

  bw_state_e        state_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] rem_q;
  logic             ovf_q;
  logic             ready_q;
  logic             valid_q;
  logic             busy_q;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic             xfer;

  assign prod_ext = {{(ACC_W-PROD_W){in_prod[PROD_W-1]}}, in_prod};
  assign xfer     = in_valid & ready_q;

  bw_sat_add #(.ACC_W(ACC_W)) u_add (
    .a_i   (acc_q),
    .b_i   (prod_ext),
    .sum_o (add_sum),
    .ovf_o (add_ovf)
  );

  // Sequencing FSM with registered handshake outputs. ready_q is held low
  // in reset so nothing is accepted until the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (xfer) begin
            acc_q  <= prod_ext;
            rem_q  <= cfg_len;
            ovf_q  <= 1'b0;
            busy_q <= 1'b1;
            if (cfg_len == '0) begin
              state_q <= HOLD;
              ready_q <= 1'b0;
              valid_q <= 1'b1;
            end else begin
              state_q <= ACC;
            end
          end
        end
        ACC: begin
          if (xfer) begin
            acc_q <= add_sum;
            ovf_q <= ovf_q | add_ovf;
            rem_q <= rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
              state_q <= HOLD;
              ready_q <= 1'b0;
              valid_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;
  assign busy      = busy_q;

endmodule
